wr_tran_tracker: RTL and testbench

// - Parametrised successor to the single-ID process memory: an ordered, hole-free table of outstanding AXI write transactions.
// - Each entry records ID and transaction type. Allocated on AW handshake; retired on B handshake (oldest entry with matching ID).
// - Raises a special-release offer for non-REGULAR head entries and a counted BLOCK-completion indication.
// - Sits beside the AXI write master, between AW/B channel sniffing and the block/release control logic.

---
 rtl/wr_tran_tracker_pkg.sv | 34 +++
 rtl/tracker_match_enc.sv | 26 ++
 rtl/wr_tran_tracker.sv | 229 ++++++++++++++++++++++
 tb/tb_wr_tran_tracker.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_tran_tracker_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wr_tran_tracker_pkg
// Brief    : Shared widths and types for the AXI write transaction tracker.
// Revision : 1.0  initial parametrised tracker
// ============================================================================
package wr_tran_tracker_pkg;

  localparam int PID_WIDTH     = 4;
  localparam int PAWUSER_WIDTH = 2;

  // Transaction type as carried on awuser.
  typedef enum logic [PAWUSER_WIDTH-1:0] {
    REGULAR = 2'd0,
    BLOCK   = 2'd1,
    DIVERT  = 2'd2
  } tran_type_e;

  // One table slot at the package default widths.
  typedef struct packed {
    logic                     valid;
    logic                     released;
    logic [PID_WIDTH-1:0]     id;
    logic [PAWUSER_WIDTH-1:0] ttype;
  } slot_t;

  // Any type other than REGULAR needs a special release.
  function automatic logic is_special(input logic [PAWUSER_WIDTH-1:0] t);
    return t != REGULAR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tracker_match_enc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tracker_match_enc
// Brief    : First-match encoder: lowest valid slot whose ID matches, as a
//            one-hot vector, plus a hit flag.
// Revision : 1.0  initial version
// ============================================================================
module tracker_match_enc #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] match,
  output logic [DEPTH-1:0] first,
  output logic             hit
);

  logic [DEPTH-1:0] req;

  assign req   = valid & match;
  // Isolate the lowest set bit: slot 0 is the oldest, so lowest index wins.
  assign first = req & (~req + DEPTH'(1));
  assign hit   = |req;

endmodule
`default_nettype wire

// File: rtl/wr_tran_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wr_tran_tracker
// Brief    : Ordered, hole-free table of outstanding AXI write transactions.
//            Allocates on AW, retires oldest matching ID on B, offers a
//            special release for non-REGULAR head entries and counts BLOCK
//            completions.
// Revision : 1.0  initial parametrised tracker
// ============================================================================
module wr_tran_tracker
  import wr_tran_tracker_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int ID_W   = PID_WIDTH,
  parameter  int USER_W = PAWUSER_WIDTH,
  localparam int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [USER_W-1:0] awuser,
  input  logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   bid,
  input  logic              block_ack,
  input  logic              release_ready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              block_fin,
  output logic              spec_release,
  output logic [USER_W-1:0] spec_type,
  output logic              bid_miss
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  localparam logic [USER_W-1:0] T_REGULAR = USER_W'(REGULAR);
  localparam logic [USER_W-1:0] T_BLOCK   = USER_W'(BLOCK);

  // Registered table and control state.
  logic [DEPTH-1:0]  slot_valid;
  logic [DEPTH-1:0]  slot_rel;
  logic [ID_W-1:0]   slot_id   [DEPTH];
  logic [USER_W-1:0] slot_type [DEPTH];
  logic [CNT_W-1:0]  block_pend;
  logic [0:0]        state;

  // Next-state values.
  logic [DEPTH-1:0]  valid_nx;
  logic [DEPTH-1:0]  rel_nx;
  logic [ID_W-1:0]   id_nx     [DEPTH];
  logic [USER_W-1:0] type_nx   [DEPTH];
  logic [CNT_W-1:0]  count_nx;
  logic [CNT_W-1:0]  pend_nx;
  logic [0:0]        state_nx;

  // Values each slot takes when the entries above it shift down.
  logic [DEPTH-1:0]  up_valid;
  logic [DEPTH-1:0]  up_rel;
  logic [ID_W-1:0]   up_id     [DEPTH];
  logic [USER_W-1:0] up_type   [DEPTH];

  logic [DEPTH-1:0]  id_match;
  logic [DEPTH-1:0]  first_hit;
  logic              hit;
  logic              aw_fire;
  logic              b_fire;
  logic              del;
  logic              head_del;
  logic              del_block;
  logic [DEPTH-1:0]  shift_mask;
  logic [CNT_W-1:0]  cnt_after_del;
  logic              head_special;
  logic              set_release;
  logic              pend_inc;
  logic              pend_dec;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign awready  = ~full;
  assign aw_fire  = awvalid & awready;
  assign b_fire   = bvalid & bready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign id_match[gi] = (slot_id[gi] == bid);
      if (gi < DEPTH-1) begin : g_mid
        assign up_valid[gi] = slot_valid[gi+1];
        assign up_rel[gi]   = slot_rel[gi+1];
        assign up_id[gi]    = slot_id[gi+1];
        assign up_type[gi]  = slot_type[gi+1];
      end else begin : g_top
        assign up_valid[gi] = 1'b0;
        assign up_rel[gi]   = 1'b0;
        assign up_id[gi]    = '0;
        assign up_type[gi]  = '0;
      end
    end
  endgenerate

  tracker_match_enc #(
    .DEPTH (DEPTH)
  ) u_match_enc (
    .valid (slot_valid),
    .match (id_match),
    .first (first_hit),
    .hit   (hit)
  );

  assign del           = b_fire & hit;
  assign head_del      = del & first_hit[0];
  assign cnt_after_del = count - CNT_W'(del);
  assign count_nx      = cnt_after_del + CNT_W'(aw_fire);

  assign head_special  = slot_valid[0] & ~slot_rel[0] & (slot_type[0] != T_REGULAR);
  assign set_release   = (state == ST_OFFER) & release_ready;

  assign block_fin     = (block_pend != '0);
  assign spec_release  = (state == ST_OFFER);
  assign spec_type     = spec_release ? slot_type[0] : '0;

  // Shift mask covers the deleted slot and everything above it; also flags BLOCK deletes.
  always_comb begin
    logic acc;
    acc        = 1'b0;
    shift_mask = '0;
    del_block  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      acc           = acc | first_hit[i];
      shift_mask[i] = acc & del;
      if (first_hit[i] && (slot_type[i] == T_BLOCK)) begin
        del_block = del;
      end
    end
  end

  // Table update: shift out the retired entry, mark a release, then append the new entry.
  always_comb begin
    valid_nx = slot_valid;
    rel_nx   = slot_rel;
    id_nx    = slot_id;
    type_nx  = slot_type;
    for (int i = 0; i < DEPTH; i++) begin
      if (shift_mask[i]) begin
        valid_nx[i] = up_valid[i];
        rel_nx[i]   = up_rel[i];
        id_nx[i]    = up_id[i];
        type_nx[i]  = up_type[i];
      end
    end
    // A release accepted together with deletion of the head is moot: the entry is gone.
    if (set_release && !head_del) begin
      rel_nx[0] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (aw_fire && (CNT_W'(i) == cnt_after_del)) begin
        valid_nx[i] = 1'b1;
        rel_nx[i]   = 1'b0;
        id_nx[i]    = awid;
        type_nx[i]  = awuser;
      end
    end
  end

  // BLOCK completion counter: increment and acknowledge cancel; saturate at DEPTH.
  always_comb begin
    pend_inc = del_block;
    pend_dec = block_ack & (block_pend != '0);
    pend_nx  = block_pend;
    if (pend_inc && !pend_dec && (block_pend != CNT_W'(DEPTH))) begin
      pend_nx = block_pend + CNT_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pend_nx = block_pend - CNT_W'(1);
    end
  end

  // Release FSM: offer a special head once; drop the offer if the head is retired.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        // A head being retired this cycle is not offered; its successor is evaluated next cycle.
        if (head_special && !head_del) begin
          state_nx = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (release_ready || head_del) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // All registered state: table, occupancy, BLOCK counter, FSM and miss pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_rel   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_id[i]   <= '0;
        slot_type[i] <= '0;
      end
      count      <= '0;
      block_pend <= '0;
      state      <= ST_IDLE;
      bid_miss   <= 1'b0;
    end else begin
      slot_valid <= valid_nx;
      slot_rel   <= rel_nx;
      for (int i = 0; i < DEPTH; i++) begin
        slot_id[i]   <= id_nx[i];
        slot_type[i] <= type_nx[i];
      end
      count      <= count_nx;
      block_pend <= pend_nx;
      state      <= state_nx;
      bid_miss   <= b_fire & ~hit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wr_tran_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wr_tran_tracker
// Brief    : Scoreboard bench for wr_tran_tracker with a queue-based model.
// Revision : 1.0  initial version
// ============================================================================
module tb_wr_tran_tracker;
  import wr_tran_tracker_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       awvalid, awready;
  logic [3:0] awid;
  logic [1:0] awuser;
  logic       bvalid, bready;
  logic [3:0] bid;
  logic       block_ack, release_ready;
  logic       full, empty;
  logic [3:0] count;
  logic       block_fin, spec_release;
  logic [1:0] spec_type;
  logic       bid_miss;

  typedef struct {
    logic [3:0] id;
    logic [1:0] ty;
    bit         rel;
  } ent_t;

  typedef struct packed {
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       awready;
    logic       block_fin;
    logic       spec_release;
    logic [1:0] spec_type;
    logic       bid_miss;
  } obs_t;

  ent_t mq[$];
  int   m_pend;
  bit   m_offer;
  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  wr_tran_tracker #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .awvalid       (awvalid),
    .awready       (awready),
    .awid          (awid),
    .awuser        (awuser),
    .bvalid        (bvalid),
    .bready        (bready),
    .bid           (bid),
    .block_ack     (block_ack),
    .release_ready (release_ready),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .block_fin     (block_fin),
    .spec_release  (spec_release),
    .spec_type     (spec_type),
    .bid_miss      (bid_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic zero_inputs();
    awvalid = 0; awid = 0; awuser = 0; bvalid = 0; bready = 0; bid = 0;
    block_ack = 0; release_ready = 0;
  endtask

  // One clock of stimulus; the model predicts outputs after the coming edge.
  task automatic step(input bit awv, input logic [3:0] aid, input logic [1:0] aty,
                      input bit bv, input bit brdy, input logic [3:0] b_id,
                      input bit back, input bit rr);
    bit   full_m, awf, bf, hd, blk, dec, nxt_offer, miss;
    int   k;
    obs_t e;
    @(negedge clk);
    awvalid = awv; awid = aid; awuser = aty;
    bvalid = bv; bready = brdy; bid = b_id;
    block_ack = back; release_ready = rr;

    full_m = (mq.size() == DEPTH);
    awf    = awv && !full_m;
    bf     = bv && brdy;
    k      = -1;
    if (bf) foreach (mq[i]) if (k < 0 && mq[i].id == b_id) k = i;
    hd  = (k == 0);
    blk = 1'b0;
    if (m_offer) nxt_offer = !(rr || hd);
    else nxt_offer = (mq.size() > 0) && !mq[0].rel && (mq[0].ty != REGULAR) && !hd;
    if (m_offer && rr && !hd) mq[0].rel = 1'b1;
    if (k >= 0) begin
      blk = (mq[k].ty == BLOCK);
      mq.delete(k);
    end
    if (awf) mq.push_back('{aid, aty, 1'b0});
    dec = back && (m_pend > 0);
    if (blk && !dec && m_pend < DEPTH) m_pend++;
    else if (dec && !blk) m_pend--;
    m_offer = nxt_offer;
    miss    = bf && (k < 0);

    e.cnt          = 4'(mq.size());
    e.full         = (mq.size() == DEPTH);
    e.empty        = (mq.size() == 0);
    e.awready      = (mq.size() != DEPTH);
    e.block_fin    = (m_pend != 0);
    e.spec_release = m_offer;
    e.spec_type    = m_offer ? mq[0].ty : 2'd0;
    e.bid_miss     = miss;
    exp_q.push_back(e);
  endtask

  task automatic aw(input logic [3:0] id, input logic [1:0] ty);
    step(1, id, ty, 0, 0, 0, 0, 0);
  endtask

  task automatic bb(input logic [3:0] id);
    step(0, 0, 0, 1, 1, id, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".full"}, 32'(full), 0);
    chk({tag, ".empty"}, 32'(empty), 1);
    chk({tag, ".awready"}, 32'(awready), 1);
    chk({tag, ".block_fin"}, 32'(block_fin), 0);
    chk({tag, ".spec_release"}, 32'(spec_release), 0);
    chk({tag, ".spec_type"}, 32'(spec_type), 0);
    chk({tag, ".bid_miss"}, 32'(bid_miss), 0);
  endtask

  // Assert reset away from the clock edge and check outputs fall to reset values at once.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    mq.delete();
    m_pend  = 0;
    m_offer = 1'b0;
    #1;
    chk_reset_vals(tag);
    @(negedge clk);
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_traffic(input int n);
    logic [3:0] b_id;
    for (int c = 0; c < n; c++) begin
      if (mq.size() > 0 && ($urandom % 4) != 0) b_id = mq[$urandom % mq.size()].id;
      else b_id = 4'($urandom % 16);
      step(($urandom % 2) == 0, 4'($urandom % 16), 2'($urandom % 3),
           ($urandom % 3) != 0, ($urandom % 4) != 0, b_id,
           ($urandom % 3) == 0, ($urandom % 3) == 0);
    end
  endtask

  // Monitor: pop the prediction for each edge and compare against the DUT.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{count, full, empty, awready, block_fin, spec_release, spec_type, bid_miss};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t: got cnt=%0d full=%b empty=%b awr=%b bfin=%b srel=%b stype=%0d miss=%b, want cnt=%0d full=%b empty=%b awr=%b bfin=%b srel=%b stype=%0d miss=%b",
                   $time, a.cnt, a.full, a.empty, a.awready, a.block_fin, a.spec_release, a.spec_type, a.bid_miss,
                   e.cnt, e.full, e.empty, e.awready, e.block_fin, e.spec_release, e.spec_type, e.bid_miss);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_inputs();
    m_pend  = 0;
    m_offer = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to capacity, overflow ignored, drain.
    for (int i = 0; i < 8; i++) aw(4'(i), REGULAR);
    settle();
    chk("fill.count", 32'(count), 8);
    chk("fill.full", 32'(full), 1);
    chk("fill.awready", 32'(awready), 0);
    aw(4'd9, REGULAR);
    settle();
    chk("overflow.count", 32'(count), 8);
    for (int i = 0; i < 8; i++) bb(4'(i));
    settle();
    chk("drain.empty", 32'(empty), 1);

    // Middle delete keeps order, next AW appends.
    aw(1, REGULAR); aw(2, REGULAR); aw(3, REGULAR);
    bb(2);
    settle();
    chk("middel.count", 32'(count), 2);
    aw(4, REGULAR);
    bb(3); bb(1); bb(4);

    // Duplicate IDs: the oldest goes first, exposing the DIVERT twin as head.
    aw(5, REGULAR); aw(5, DIVERT); aw(7, REGULAR);
    bb(5);
    settle();
    chk("dup.count", 32'(count), 2);
    idle();
    settle();
    chk("dup.spec_release", 32'(spec_release), 1);
    chk("dup.spec_type", 32'(spec_type), 32'(DIVERT));
    step(0, 0, 0, 0, 0, 0, 0, 1);
    bb(5); bb(7);

    // Unknown ID.
    aw(2, REGULAR);
    bb(9);
    settle();
    chk("miss.pulse", 32'(bid_miss), 1);
    chk("miss.count", 32'(count), 1);
    idle();
    settle();
    chk("miss.drop", 32'(bid_miss), 0);
    bb(2);

    // Full table: delete and AW together does not allocate; next cycle does.
    for (int i = 0; i < 8; i++) aw(4'(i), REGULAR);
    step(1, 4'd8, REGULAR, 1, 1, 4'd3, 0, 0);
    settle();
    chk("simul.count", 32'(count), 7);
    aw(8, REGULAR);
    settle();
    chk("simul.refill", 32'(count), 8);
    chk("simul.full", 32'(full), 1);
    bb(0); bb(1); bb(2); bb(4); bb(5); bb(6); bb(7); bb(8);

    // Two BLOCK completions, then two acknowledges.
    aw(1, BLOCK); aw(2, BLOCK);
    bb(1); bb(2);
    settle();
    chk("block.fin", 32'(block_fin), 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("block.ack1", 32'(block_fin), 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("block.ack2", 32'(block_fin), 0);

    // Release offer, acceptance, no re-offer, head deletion during offer.
    aw(3, DIVERT);
    idle();
    settle();
    chk("rel.offer", 32'(spec_release), 1);
    chk("rel.type", 32'(spec_type), 32'(DIVERT));
    step(0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("rel.accept", 32'(spec_release), 0);
    idle(); idle();
    settle();
    chk("rel.no_reoffer", 32'(spec_release), 0);
    aw(4, DIVERT);
    bb(3);
    idle();
    settle();
    chk("rel.next_head", 32'(spec_release), 1);
    bb(4);
    settle();
    chk("rel.head_del", 32'(spec_release), 0);
    chk("rel.empty", 32'(empty), 1);

    // Randomised traffic, reset in the middle, then restart.
    rand_traffic(1500);
    do_reset("midreset");
    rand_traffic(500);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
